// File: rtl/perf_counter_unit.sv
// Performance monitor: cycle, retired-instruction and event counters, snapshot, fixed-point CPI.
// Latency: counters update every enabled edge; CPI result arrives CNT_W+FRAC+1 cycles after an accepted snap.
// Backpressure: none on counting; a snap arriving while the divider is busy is dropped.
//
// Ports:
//   clk, rst (async, active-low)       clock and reset
//   en, clear                          count enable; synchronous clear of live counters and ovf
//   retire_cnt, evt                    per-cycle increments (instructions, event strobes)
//   snap                               freeze live counters and start the CPI division
//   rd_sel / rd_data                   combinational snapshot read (0=cycles, 1=instrs, 2+k=event k)
//   ovf                                sticky overflow flags, same index map as rd_sel
//   cpi, cpi_busy, cpi_valid, div0     CPI result (FRAC fractional bits) and status
module perf_counter_unit #(
  parameter int CNT_W   = 32,
  parameter int NUM_EVT = 4,
  parameter int RET_W   = 2,
  parameter int FRAC    = 8,
  parameter int SAT     = 0,
  localparam int NCNT   = NUM_EVT + 2,
  localparam int SEL_W  = $clog2(NUM_EVT + 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clear,
  input  logic [RET_W-1:0]   retire_cnt,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               snap,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [CNT_W-1:0]   rd_data,
  output logic [NCNT-1:0]    ovf,
  output logic [CNT_W-1:0]   cpi,
  output logic               cpi_busy,
  output logic               cpi_valid,
  output logic               div0
);

  localparam int QW     = CNT_W + FRAC;
  localparam int STEP_W = $clog2(QW + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q  [NCNT];
  logic [CNT_W-1:0]  snap_q [NCNT];
  logic [NCNT-1:0]   ovf_q;
  logic [CNT_W:0]    inc    [NCNT];
  logic [CNT_W:0]    sum    [NCNT];
  logic [CNT_W-1:0]  nxt    [NCNT];

  logic [CNT_W-1:0]  rem_q;
  logic [QW-1:0]     quo_q;
  logic [STEP_W-1:0] step_q;
  logic [CNT_W-1:0]  cpi_q;
  logic              cpi_valid_q;
  logic              div0_q;

  logic              load;
  logic              step_en;
  logic              finish;
  logic              snap_acc;

  logic [CNT_W:0]    trial;
  logic              trial_ge;
  logic [CNT_W-1:0]  rem_nxt;
  logic              over;
  logic [CNT_W-1:0]  quo_clip;

  // ---------------------------------------------------------------------------
  // Live counters. Each sum carries one extra bit so the carry-out doubles as
  // the overflow detector for both wrap and saturate modes.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NCNT; i++) inc[i] = '0;
    inc[0] = (CNT_W+1)'(1);
    inc[1] = (CNT_W+1)'(retire_cnt);
    for (int k = 0; k < NUM_EVT; k++) inc[k+2] = (CNT_W+1)'(evt[k]);
  end

  always_comb begin
    for (int i = 0; i < NCNT; i++) begin
      sum[i] = {1'b0, cnt_q[i]} + inc[i];
      if (sum[i][CNT_W] && (SAT != 0)) nxt[i] = '1;
      else                             nxt[i] = sum[i][CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
      ovf_q <= '0;
    end else if (clear) begin
      // clear wins over any increment on the same edge
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
      ovf_q <= '0;
    end else if (en) begin
      for (int i = 0; i < NCNT; i++) begin
        cnt_q[i] <= nxt[i];
        if (sum[i][CNT_W]) ovf_q[i] <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Snapshot: captures pre-edge live values, so a same-edge clear or increment
  // is not seen by the snapshot.
  // ---------------------------------------------------------------------------
  assign snap_acc = snap && (state_q == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCNT; i++) snap_q[i] <= '0;
    end else if (snap_acc) begin
      for (int i = 0; i < NCNT; i++) snap_q[i] <= cnt_q[i];
    end
  end

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_sel} < (SEL_W+1)'(NCNT)) rd_data = snap_q[rd_sel];
  end

  // ---------------------------------------------------------------------------
  // CPI control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step_en = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (snap) begin
          load    = 1'b1;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        step_en = 1'b1;
        if (step_q == STEP_W'(QW - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        finish  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Restoring divider. quo_q starts as the dividend and shifts left; quotient
  // bits enter at the bottom. The remainder stays below the divisor, so
  // CNT_W bits hold it and the subtraction can be done modulo 2^CNT_W.
  // A zero divisor makes every trial succeed; the result is forced anyway.
  // ---------------------------------------------------------------------------
  assign trial    = {rem_q, quo_q[QW-1]};
  assign trial_ge = trial >= {1'b0, snap_q[1]};
  assign rem_nxt  = trial_ge ? (trial[CNT_W-1:0] - snap_q[1]) : trial[CNT_W-1:0];
  assign over     = (quo_q >> CNT_W) != '0;
  assign quo_clip = over ? '1 : quo_q[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q       <= '0;
      quo_q       <= '0;
      step_q      <= '0;
      cpi_q       <= '0;
      cpi_valid_q <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      cpi_valid_q <= 1'b0;
      if (load) begin
        rem_q  <= '0;
        quo_q  <= QW'(cnt_q[0]) << FRAC;
        step_q <= '0;
      end
      if (step_en) begin
        rem_q  <= rem_nxt;
        quo_q  <= {quo_q[QW-2:0], trial_ge};
        step_q <= step_q + STEP_W'(1);
      end
      if (finish) begin
        cpi_valid_q <= 1'b1;
        if (snap_q[1] == '0) begin
          cpi_q  <= '1;
          div0_q <= 1'b1;
        end else begin
          cpi_q  <= quo_clip;
          div0_q <= 1'b0;
        end
      end
    end
  end

  assign ovf       = ovf_q;
  assign cpi       = cpi_q;
  assign cpi_busy  = (state_q != S_IDLE);
  assign cpi_valid = cpi_valid_q;
  assign div0      = div0_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
module tb_perf_counter_unit;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clear;
  logic [1:0]  retire_cnt;
  logic [3:0]  evt;
  logic        snap;
  logic [2:0]  rd_sel;

  logic [31:0] rd_data;
  logic [5:0]  ovf;
  logic [31:0] cpi;
  logic        cpi_busy;
  logic        cpi_valid;
  logic        div0;

  logic [7:0]  a_rd_data, b_rd_data;
  logic [5:0]  a_ovf, b_ovf;
  logic [7:0]  a_cpi, b_cpi;
  logic        a_busy, b_busy, a_valid, b_valid, a_div0, b_div0;

  int checks   = 0;
  int failures = 0;

  perf_counter_unit dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .retire_cnt(retire_cnt), .evt(evt),
    .snap(snap), .rd_sel(rd_sel), .rd_data(rd_data), .ovf(ovf), .cpi(cpi),
    .cpi_busy(cpi_busy), .cpi_valid(cpi_valid), .div0(div0)
  );

  perf_counter_unit #(.CNT_W(8), .SAT(0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .retire_cnt(retire_cnt), .evt(evt),
    .snap(snap), .rd_sel(rd_sel), .rd_data(a_rd_data), .ovf(a_ovf), .cpi(a_cpi),
    .cpi_busy(a_busy), .cpi_valid(a_valid), .div0(a_div0)
  );

  perf_counter_unit #(.CNT_W(8), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .retire_cnt(retire_cnt), .evt(evt),
    .snap(snap), .rd_sel(rd_sel), .rd_data(b_rd_data), .ovf(b_ovf), .cpi(b_cpi),
    .cpi_busy(b_busy), .cpi_valid(b_valid), .div0(b_div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish within 200000 ns");
    $fatal(1, "timeout");
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (cpi_busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (cpi_busy) begin
      checks++; failures++;
      $display("FAIL wait_idle cpi_busy still high after %0d cycles", t);
    end
  endtask

  task automatic wait_valid(output int t);
    t = 0;
    while (!cpi_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rd_sel = 3'd0; #1;
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL reset_rd_data got=%h exp=%h", rd_data, 32'd0); end
    checks++; if (ovf !== 6'd0) begin failures++; $display("FAIL reset_ovf got=%h exp=%h", ovf, 6'd0); end
    checks++; if (cpi !== 32'd0) begin failures++; $display("FAIL reset_cpi got=%h exp=%h", cpi, 32'd0); end
    checks++; if ({cpi_busy, cpi_valid, div0} !== 3'b000) begin failures++; $display("FAIL reset_status got=%b exp=000", {cpi_busy, cpi_valid, div0}); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_count_cpi();
    int t;
    en = 1'b1; retire_cnt = 2'd1;
    repeat (100) @(negedge clk);
    snap = 1'b1;                     // en still high on this edge: snapshot is pre-increment
    @(negedge clk);
    snap = 1'b0; en = 1'b0; retire_cnt = 2'd0;
    checks++; if (cpi_busy !== 1'b1) begin failures++; $display("FAIL cnt_busy got=%b exp=1", cpi_busy); end
    wait_valid(t);
    checks++; if (t != 41) begin failures++; $display("FAIL cnt_latency got=%0d exp=41", t); end
    checks++; if (cpi !== 32'h100) begin failures++; $display("FAIL cnt_cpi got=%h exp=%h", cpi, 32'h100); end
    checks++; if (div0 !== 1'b0) begin failures++; $display("FAIL cnt_div0 got=%b exp=0", div0); end
    @(negedge clk);
    checks++; if (cpi_valid !== 1'b0) begin failures++; $display("FAIL cnt_valid_pulse got=%b exp=0", cpi_valid); end
    rd_sel = 3'd0; #1;
    checks++; if (rd_data !== 32'd100) begin failures++; $display("FAIL cnt_cycles got=%0d exp=100", rd_data); end
    rd_sel = 3'd1; #1;
    checks++; if (rd_data !== 32'd100) begin failures++; $display("FAIL cnt_instrs got=%0d exp=100", rd_data); end
  endtask

  task automatic test_div0();
    int t, nvalid, first;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; en = 1'b1; retire_cnt = 2'd0;
    repeat (10) @(negedge clk);
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    t = 0; nvalid = 0; first = -1;
    for (int i = 0; i < 60; i++) begin
      if (t == 5) snap = 1'b1;       // must be ignored: divider busy
      if (t == 6) snap = 1'b0;
      @(negedge clk);
      t++;
      if (cpi_valid) begin
        nvalid++;
        if (first < 0) first = t;
      end
    end
    en = 1'b0;
    checks++; if (first != 41) begin failures++; $display("FAIL div0_latency got=%0d exp=41", first); end
    checks++; if (nvalid != 1) begin failures++; $display("FAIL div0_valid_count got=%0d exp=1", nvalid); end
    checks++; if (cpi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0_cpi got=%h exp=%h", cpi, 32'hFFFF_FFFF); end
    checks++; if (div0 !== 1'b1) begin failures++; $display("FAIL div0_flag got=%b exp=1", div0); end
    rd_sel = 3'd0; #1;
    checks++; if (rd_data !== 32'd10) begin failures++; $display("FAIL div0_snap_cycles got=%0d exp=10", rd_data); end
    rd_sel = 3'd1; #1;
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL div0_snap_instrs got=%0d exp=0", rd_data); end
  endtask

  task automatic test_half_rate();
    int t;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 200; i++) begin
      en = 1'b1;
      retire_cnt = (i % 2 == 0) ? 2'd1 : 2'd0;
      @(negedge clk);
    end
    en = 1'b0; retire_cnt = 2'd0; snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    wait_valid(t);
    checks++; if (t != 41) begin failures++; $display("FAIL half_latency got=%0d exp=41", t); end
    checks++; if (cpi !== 32'h200) begin failures++; $display("FAIL half_cpi got=%h exp=%h", cpi, 32'h200); end
    checks++; if (div0 !== 1'b0) begin failures++; $display("FAIL half_div0 got=%b exp=0", div0); end
    rd_sel = 3'd0; #1;
    checks++; if (rd_data !== 32'd200) begin failures++; $display("FAIL half_cycles got=%0d exp=200", rd_data); end
    rd_sel = 3'd1; #1;
    checks++; if (rd_data !== 32'd100) begin failures++; $display("FAIL half_instrs got=%0d exp=100", rd_data); end
  endtask

  task automatic test_overflow();
    wait_idle();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; en = 1'b1; evt = 4'b0001;
    repeat (260) @(negedge clk);
    en = 1'b0; evt = 4'b0000; snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    rd_sel = 3'd2; #1;
    checks++; if (a_rd_data !== 8'd4) begin failures++; $display("FAIL ovf_wrap_evt0 got=%0d exp=4", a_rd_data); end
    checks++; if (b_rd_data !== 8'd255) begin failures++; $display("FAIL ovf_sat_evt0 got=%0d exp=255", b_rd_data); end
    checks++; if (rd_data !== 32'd260) begin failures++; $display("FAIL ovf_wide_evt0 got=%0d exp=260", rd_data); end
    checks++; if (a_ovf[2] !== 1'b1) begin failures++; $display("FAIL ovf_wrap_flag got=%b exp=1", a_ovf[2]); end
    checks++; if (b_ovf[2] !== 1'b1) begin failures++; $display("FAIL ovf_sat_flag got=%b exp=1", b_ovf[2]); end
    checks++; if (a_ovf[3] !== 1'b0) begin failures++; $display("FAIL ovf_wrap_evt1_flag got=%b exp=0", a_ovf[3]); end
    checks++; if (ovf !== 6'd0) begin failures++; $display("FAIL ovf_wide_flags got=%h exp=%h", ovf, 6'd0); end
  endtask

  task automatic test_clear();
    wait_idle();
    en = 1'b1; evt = 4'b0010;
    repeat (3) @(negedge clk);
    clear = 1'b1;                    // increment on this edge must lose to clear
    @(negedge clk);
    clear = 1'b0; en = 1'b0; evt = 4'b0000;
    checks++; if (a_ovf !== 6'd0) begin failures++; $display("FAIL clr_ovf got=%h exp=%h", a_ovf, 6'd0); end
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    rd_sel = 3'd3; #1;
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL clr_evt1 got=%0d exp=0", rd_data); end
    wait_idle();
    en = 1'b1; evt = 4'b0010;
    repeat (7) @(negedge clk);
    snap = 1'b1; clear = 1'b1;
    @(negedge clk);
    snap = 1'b0; clear = 1'b0; en = 1'b0; evt = 4'b0000;
    rd_sel = 3'd3; #1;
    checks++; if (rd_data !== 32'd7) begin failures++; $display("FAIL snapclr_evt1 got=%0d exp=7", rd_data); end
    rd_sel = 3'd0; #1;
    checks++; if (rd_data !== 32'd7) begin failures++; $display("FAIL snapclr_cycles got=%0d exp=7", rd_data); end
    rd_sel = 3'd6; #1;
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL rdsel_6 got=%0d exp=0", rd_data); end
    rd_sel = 3'd7; #1;
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL rdsel_7 got=%0d exp=0", rd_data); end
    wait_idle();
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    rd_sel = 3'd0; #1;
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL snapclr_live_cleared got=%0d exp=0", rd_data); end
  endtask

  task automatic test_async_reset();
    int nvalid;
    wait_idle();
    en = 1'b1; retire_cnt = 2'd1;
    repeat (20) @(negedge clk);
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (cpi_busy !== 1'b1) begin failures++; $display("FAIL arst_pre_busy got=%b exp=1", cpi_busy); end
    rd_sel = 3'd0;
    #3 rst = 1'b0;
    #1;
    checks++; if (cpi_busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", cpi_busy); end
    checks++; if (cpi !== 32'd0) begin failures++; $display("FAIL arst_cpi got=%h exp=%h", cpi, 32'd0); end
    checks++; if (div0 !== 1'b0) begin failures++; $display("FAIL arst_div0 got=%b exp=0", div0); end
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL arst_rd_data got=%0d exp=0", rd_data); end
    checks++; if ({ovf, cpi_valid} !== 7'd0) begin failures++; $display("FAIL arst_ovf_valid got=%b exp=0", {ovf, cpi_valid}); end
    @(negedge clk);
    rst = 1'b1; en = 1'b0; retire_cnt = 2'd0;
    nvalid = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cpi_valid) nvalid++;
    end
    checks++; if (nvalid != 0) begin failures++; $display("FAIL arst_no_valid got=%0d exp=0", nvalid); end
    en = 1'b1; retire_cnt = 2'd1;
    repeat (5) @(negedge clk);
    en = 1'b0; retire_cnt = 2'd0; snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    rd_sel = 3'd0; #1;
    checks++; if (rd_data !== 32'd5) begin failures++; $display("FAIL arst_restart_cycles got=%0d exp=5", rd_data); end
    rd_sel = 3'd1; #1;
    checks++; if (rd_data !== 32'd5) begin failures++; $display("FAIL arst_restart_instrs got=%0d exp=5", rd_data); end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; clear = 1'b0; retire_cnt = 2'd0;
    evt = 4'd0; snap = 1'b0; rd_sel = 3'd0;
    test_reset();
    test_count_cpi();
    test_div0();
    test_half_rate();
    test_overflow();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
